// File: rtl/serial_pattern_sequencer_pkg.sv
// Shared state encoding and default widths for the serial pattern sequencer.
package serial_pattern_sequencer_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int REP_W_DEF = 4;
  localparam int GAP_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_GAP   = 3'd2,
    S_CHK   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/serial_pattern_sequencer_seq_bit_counter.sv
// Loadable down-counter; load wins over decrement.
module seq_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/serial_pattern_sequencer.sv
// Sequences a serial-in shift-register datapath: shifts a pattern MSB-first
// rep+1 times with idle gaps, and checks the datapath output after each pass.
module serial_pattern_sequencer
  import serial_pattern_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] rep,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             a,
  output logic             shift_en,
  input  logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             check_err,
  output logic [REP_W:0]   pass_cnt
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(WIDTH - 1);
  localparam logic [REP_W:0]   CNT_ONE  = (REP_W + 1)'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_pattern;
  logic [GAP_W-1:0] r_gap;
  logic             r_a, r_shift_en, r_start_ready, r_busy, r_done;
  logic             r_check_err, r_chk;
  logic [REP_W:0]   r_pass_cnt;

  logic [BIT_W-1:0] w_bit_idx, w_next_idx;
  logic [GAP_W-1:0] w_gap_cnt;
  logic [REP_W-1:0] w_reps_left;
  logic w_accept, w_last_bit, w_more, w_back2back, w_to_gap, w_gap_end, w_next_pass;

  assign w_accept    = (r_state == S_IDLE) && start_valid && !abort;
  assign w_last_bit  = (r_state == S_SHIFT) && (w_bit_idx == '0);
  assign w_more      = (w_reps_left != '0);
  assign w_back2back = w_last_bit && w_more && (r_gap == '0);
  assign w_to_gap    = w_last_bit && w_more && (r_gap != '0);
  assign w_gap_end   = (r_state == S_GAP) && (w_gap_cnt == GAP_W'(1));
  assign w_next_pass = !abort && (w_back2back || w_gap_end);
  assign w_next_idx  = w_bit_idx - BIT_W'(1);

  seq_bit_counter #(.W(BIT_W)) u_bit_idx (
    .clk(clk), .rst_n(rst_n),
    .i_load(w_accept || w_next_pass), .i_load_val(LAST_IDX),
    .i_dec((r_state == S_SHIFT) && !w_last_bit && !abort),
    .o_count(w_bit_idx)
  );

  seq_bit_counter #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .rst_n(rst_n),
    .i_load(w_to_gap && !abort), .i_load_val(r_gap),
    .i_dec(r_state == S_GAP),
    .o_count(w_gap_cnt)
  );

  seq_bit_counter #(.W(REP_W)) u_reps_left (
    .clk(clk), .rst_n(rst_n),
    .i_load(w_accept), .i_load_val(rep),
    .i_dec(w_next_pass),
    .o_count(w_reps_left)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pattern     <= '0;
      r_gap         <= '0;
      r_a           <= 1'b0;
      r_shift_en    <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_check_err   <= 1'b0;
      r_chk         <= 1'b0;
      r_pass_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      r_chk  <= 1'b0;
      // r_chk marks the cycle right after a pass's last shift, when r holds the full pass
      if (r_chk && !abort) begin
        r_pass_cnt <= r_pass_cnt + CNT_ONE;
        if (r != r_pattern) r_check_err <= 1'b1;
      end
      if (abort && (r_state != S_IDLE)) begin
        r_state       <= S_IDLE;
        r_a           <= 1'b0;
        r_shift_en    <= 1'b0;
        r_busy        <= 1'b0;
        r_start_ready <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_pattern     <= pattern;
              r_gap         <= gap;
              r_check_err   <= 1'b0;
              r_pass_cnt    <= '0;
              r_state       <= S_SHIFT;
              r_a           <= pattern[WIDTH-1];
              r_shift_en    <= 1'b1;
              r_busy        <= 1'b1;
              r_start_ready <= 1'b0;
            end
          end
          S_SHIFT: begin
            if (w_last_bit) begin
              r_chk <= 1'b1;
              if (!w_more) begin
                r_state    <= S_CHK;
                r_a        <= 1'b0;
                r_shift_en <= 1'b0;
              end else if (r_gap == '0) begin
                r_a <= r_pattern[WIDTH-1];
              end else begin
                r_state    <= S_GAP;
                r_a        <= 1'b0;
                r_shift_en <= 1'b0;
              end
            end else begin
              r_a <= r_pattern[w_next_idx];
            end
          end
          S_GAP: begin
            if (w_gap_end) begin
              r_state    <= S_SHIFT;
              r_a        <= r_pattern[WIDTH-1];
              r_shift_en <= 1'b1;
            end
          end
          S_CHK: begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
          S_DONE: begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
          default: begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_start_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign a           = r_a;
  assign shift_en    = r_shift_en;
  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign check_err   = r_check_err;
  assign pass_cnt    = r_pass_cnt;

endmodule

// File: tb/tb_serial_pattern_sequencer.sv
// Scoreboard bench: commands push expected results, a monitor checks each done.
module tb_serial_pattern_sequencer;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [3:0] pattern = '0;
  logic [3:0] rep = '0;
  logic [3:0] gap = '0;
  logic       abort = 1'b0;
  logic       a, shift_en, busy, done, check_err;
  logic [4:0] pass_cnt;
  logic [3:0] dp_r = '0;
  logic [3:0] r_in;

  int cyc = 0;
  int bad_cyc = -1;
  int n_pass = 0;
  int n_total = 0;
  int acc_cyc = 0;
  int mon_n = 0;
  logic [127:0] mon_bits = '0;

  typedef struct {
    int           lat;
    bit           err;
    int           passes;
    int           nbits;
    logic [127:0] bits;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Real 4-bit serial-in datapath; never reset by the sequencer.
  always @(posedge clk) if (shift_en) dp_r <= {dp_r[2:0], a};
  assign r_in = (cyc == bad_cyc) ? 4'b0000 : dp_r;

  serial_pattern_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .pattern(pattern), .rep(rep), .gap(gap), .abort(abort), .a(a), .shift_en(shift_en),
    .r(r_in), .busy(busy), .done(done), .check_err(check_err), .pass_cnt(pass_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic push_exp(input logic [3:0] p, input logic [3:0] rp, input logic [3:0] g,
                          input bit err);
    exp_t e;
    e.passes = int'(rp) + 1;
    e.lat    = e.passes * W + int'(rp) * int'(g) + 2;
    e.err    = err;
    e.nbits  = e.passes * W;
    e.bits   = '0;
    for (int i = 0; i < e.passes; i++) e.bits = (e.bits << W) | 128'(p);
    exp_q.push_back(e);
  endtask

  // Monitor: tracks accepts and shifted bits, checks every done against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_n    = 0;
      mon_bits = '0;
    end else begin
      if (start_valid && start_ready && !abort) begin
        acc_cyc  = cyc;
        mon_n    = 0;
        mon_bits = '0;
      end
      if (shift_en) begin
        mon_bits = {mon_bits[126:0], a};
        mon_n++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("latency", 128'(cyc - acc_cyc), 128'(e.lat));
          chk("check_err", 128'(check_err), 128'(e.err));
          chk("pass_cnt", 128'(pass_cnt), 128'(e.passes));
          chk("shift_count", 128'(mon_n), 128'(e.nbits));
          chk("serial_bits", mon_bits, e.bits);
        end
      end
    end
  end

  task automatic send(input logic [3:0] p, input logic [3:0] rp, input logic [3:0] g,
                      input bit corrupt, input int cpass, input bit push, output int acc);
    @(posedge clk); #1;
    pattern = p; rep = rp; gap = g; start_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(negedge clk);
      if (start_ready && !abort) acc = cyc;
    end
    if (acc < 0) begin
      chk("accept_timeout", 0, 1);
    end else begin
      if (corrupt) bad_cyc = acc + (cpass + 1) * W + cpass * int'(g) + 1;
      if (push) push_exp(p, rp, g, corrupt && (p != 4'b0000));
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    pattern = 4'($urandom); rep = 4'($urandom); gap = 4'($urandom);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a"}, 128'(a), 0);
    chk({tag, "_shift_en"}, 128'(shift_en), 0);
    chk({tag, "_start_ready"}, 128'(start_ready), 1);
    chk({tag, "_busy"}, 128'(busy), 0);
    chk({tag, "_done"}, 128'(done), 0);
    chk({tag, "_check_err"}, 128'(check_err), 0);
    chk({tag, "_pass_cnt"}, 128'(pass_cnt), 0);
  endtask

  initial begin
    int acc, acc2, nacc;
    logic [3:0] p, rp, g;
    bit corrupt;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    send(4'b1011, 4'd0, 4'd0, 1'b0, 0, 1'b1, acc);
    wait_idle();
    send(4'b0110, 4'd2, 4'd3, 1'b0, 0, 1'b1, acc);
    wait_idle();
    send(4'b1100, 4'd1, 4'd0, 1'b0, 0, 1'b1, acc);
    wait_idle();
    send(4'b1001, 4'd1, 4'd0, 1'b1, 1, 1'b1, acc);
    wait_idle();
    send(4'b0101, 4'd0, 4'd2, 1'b0, 0, 1'b1, acc);
    wait_idle();

    // Abort on the third SHIFT cycle.
    send(4'b1111, 4'd3, 4'd1, 1'b0, 0, 1'b0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_shift_en", 128'(shift_en), 0);
    chk("abort_a", 128'(a), 0);
    chk("abort_busy", 128'(busy), 0);
    chk("abort_start_ready", 128'(start_ready), 1);
    chk("abort_pass_cnt", 128'(pass_cnt), 0);
    repeat (30) @(negedge clk);

    // Abort in IDLE blocks a simultaneous start.
    @(posedge clk); #1 start_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_busy", 128'(busy), 0);

    // Async reset in the middle of a GAP.
    send(4'b1010, 4'd1, 4'd5, 1'b0, 0, 1'b0, acc);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("midgap");
    @(posedge clk); #1 rst_n = 1'b1;
    send(4'b0011, 4'd0, 4'd0, 1'b0, 0, 1'b1, acc);
    wait_idle();

    // Maximum repeat count gives 2^REP_W passes.
    send(4'b1101, 4'd15, 4'd0, 1'b0, 0, 1'b1, acc);
    wait_idle();

    // start_valid held high re-accepts in the IDLE cycle after DONE.
    @(posedge clk); #1;
    p = 4'($urandom); pattern = p; rep = 4'd0; gap = 4'd0; start_valid = 1'b1;
    nacc = 0; acc = -1; acc2 = -1;
    for (int i = 0; i < 60 && nacc < 2; i++) begin
      @(negedge clk);
      if (start_ready && !abort) begin
        if (nacc == 0) acc = cyc; else acc2 = cyc;
        push_exp(p, 4'd0, 4'd0, 1'b0);
        nacc++;
      end
    end
    @(posedge clk); #1 start_valid = 1'b0;
    chk("reaccept_spacing", 128'(acc2 - acc), 128'(W + 3));
    wait_idle();

    for (int k = 0; k < 15; k++) begin
      p = 4'($urandom);
      rp = 4'($urandom_range(0, 3));
      g = 4'($urandom_range(0, 3));
      corrupt = 1'($urandom_range(0, 1));
      send(p, rp, g, corrupt, int'($urandom_range(0, int'(rp))), 1'b1, acc);
      wait_idle();
    end

    chk("queue_drained", 128'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
